mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and sequencer for the shared 4-input, 4-bit mux datapath. Four requesters compete for the shared output bus. The block grants exactly one requester at a time, drives the mux select `s` to match the grant, and enforces a bounded hold time so that no requester can starve the others. It sits directly in front of the 4-to-1 mux and owns its select line.

## Interface
- `HOLD_MAX`, 8: maximum consecutive cycles one holder keeps the grant while others are pending; legal range 2..256.
- `clk`  input  1  system clock, rising-edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req`  input  4  request per requester; bit i = requester i (mux input Ii).
- `gnt`  output  4  registered one-hot grant, or all-zero when idle.
- `s`  output  2  registered mux select; equals the index of the granted bit while `busy`.
- `busy`  output  1  high while any grant is active.
- `switch`  output  1  one-cycle pulse on the edge a grant moves from one requester to a different one.

## Operation
- State `IDLE`: no grant.
  - If `req` != 0: select the winner, load `gnt`, `s`, `cnt`=0 and go to `GRANT`.
  - If `req` == 0: stay in `IDLE`.
- State `GRANT`: holder h = `s`.
  - `req[h]`=1 and `cnt` < `HOLD_MAX`-1: keep the grant and increment `cnt`.
  - `req[h]`=1, `cnt` = `HOLD_MAX`-1, another bit pending: forced handover to the next winner (search starts at h+1) and `cnt`=0.
  - `req[h]`=1, `cnt` = `HOLD_MAX`-1, no other bit pending: keep the grant, `cnt`=0, no `switch`.
  - `req[h]`=0 and another bit pending: handover to the next winner and `cnt`=0.
  - `req[h]`=0 and no bit pending: `gnt`=0000, `busy`=0, go to `IDLE`.
- Winner selection: the first set bit of `req` scanning ptr, ptr+1, ... (mod 4).
- `ptr` is a 2-bit register, reset 0. It is loaded with winner+1 (wraps 3→0) on every new grant.
- `cnt` width is clog2(`HOLD_MAX`). It never exceeds `HOLD_MAX`-1.
- `s` keeps its last value in `IDLE`; it does not return to 0.
- `switch` = 1 only when the new `gnt` is nonzero and differs from the previous nonzero `gnt`. An `IDLE`→`GRANT` transition does not raise `switch`.
- Requester protocol:
  - Raise `req[i]` and hold it until `gnt[i]` is seen.
  - Drop `req[i]` to release the bus.
  - A requester whose grant was revoked by timeout must keep `req[i]` high to be re-queued.
- Invariant: `gnt` is one-hot or zero at all times, and `busy` = |`gnt`.

## Timing
- All outputs are registered. Reset values: `gnt`=0000, `s`=00, `busy`=0, `switch`=0. Internal reset values: state `IDLE`, `ptr`=0, `cnt`=0.
- Reset is asynchronous. `rst_n` low clears all outputs immediately, including in the middle of a grant. The first grant can occur on the first rising edge after `rst_n` rises.
- Grant latency: `req` sampled at edge k → `gnt`/`s`/`busy` valid after edge k (1 cycle).
- Release: `req[h]` low sampled at edge k → the new `gnt` (or 0000) is valid after edge k.
- Handover has no bubble: `busy` stays 1 and `s` changes on the same edge as `gnt`.
- Bound: with contention, a holder keeps the bus at most `HOLD_MAX` consecutive cycles.
- Worst-case wait for a continuously requesting requester is 3·`HOLD_MAX` cycles after its first sampled `req`.
- Simultaneous request arrivals are resolved only by `ptr` order.
- A requester that drops `req` on the same edge its grant arrives still receives a 1-cycle grant, which is released on the next edge.

## Test plan
- Reset: grant `gnt`=0100, then pull `rst_n` low between edges → `gnt`=0000, `s`=00, `busy`=0 without waiting for a clock edge. After release, `req`=1000 → `gnt`=1000 and `s`=11 one edge later.
- Single request: `req`=0100 at edge 0 → after edge 0, `gnt`=0100, `s`=10, `busy`=1. Drop `req` at edge 3 → after edge 3, `gnt`=0000, `busy`=0, and `s` stays 10.
- Round-robin order: `req`=1111 from reset, with each holder dropping its bit for one cycle after 2 granted cycles → grant sequence 0001, 0010, 0100, 1000, 0001. `switch` pulses on each change and `busy` never drops.
- Timeout with contention (`HOLD_MAX`=8): `req`=0011 held constantly → `gnt`=0001 for 8 cycles, then 0010 for 8 cycles, alternating. `switch` pulses once per 8 cycles.
- Timeout without contention: only `req`=0001 held for 20 cycles → `gnt`=0001 throughout, `switch` never pulses, and `cnt` wraps to 0 each 8 cycles.
- Zero-bubble handover with wrap: holder 3 (`s`=11) drops `req` while `req[1]`=1 → `gnt` goes 1000→0010 on one edge, `s`=01, `busy` stays 1. The next search starts at index 2.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and the round-robin arbiter.
// The arbiter drives the mux select s alongside the one-hot grant.
interface mux4_rr_arbiter_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] s;
   logic       busy;
   logic       switch;

   modport master (output req, input gnt, s, busy, switch);
   modport slave  (input req, output gnt, s, busy, switch);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for the shared 4-to-1 mux: one-hot grant, matching select,
// and a hold-time limit that forces a handover when other requesters are waiting.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no grant; s keeps its last value
//   S_GRANT | requester s holds the bus; cnt counts its consecutive cycles
module mux4_rr_arbiter #(
   parameter int HOLD_MAX = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   mux4_rr_arbiter_if.slave   bus
);

   localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t        state_q, state_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [1:0]    s_q, s_d;
   logic          busy_q, busy_d;
   logic          switch_q, switch_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [3:0] others, src;
   logic [1:0] start, win;
   logic       load;

   // First set bit of r, scanning start, start+1, ... modulo 4.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] first);
      logic [1:0] idx;
      logic [1:0] sel;
      logic       found;
      sel   = first;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = first + 2'(i);
         if (!found && r[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         gnt_q    <= 4'b0000;
         s_q      <= 2'b00;
         busy_q   <= 1'b0;
         switch_q <= 1'b0;
         ptr_q    <= 2'b00;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         s_q      <= s_d;
         busy_q   <= busy_d;
         switch_q <= switch_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // From IDLE the search starts at ptr; on a handover it starts just past the holder.
   always_comb begin
      others = bus.req & ~(4'b0001 << s_q);
      src    = (state_q == S_IDLE) ? bus.req : others;
      start  = (state_q == S_IDLE) ? ptr_q : s_q + 2'd1;
      win    = pick(src, start);
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      s_d      = s_q;
      busy_d   = busy_q;
      switch_d = 1'b0;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      load     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (|bus.req) load = 1'b1;
         end
         S_GRANT: begin
            if (bus.req[s_q] && cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + CW'(1);
            end else if (|others) begin
               load     = 1'b1;
               switch_d = 1'b1;
            end else if (bus.req[s_q]) begin
               cnt_d = '0;
            end else begin
               state_d = S_IDLE;
               gnt_d   = 4'b0000;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         state_d = S_GRANT;
         gnt_d   = 4'b0001 << win;
         s_d     = win;
         busy_d  = 1'b1;
         cnt_d   = '0;
         ptr_d   = win + 2'd1;
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.s      = s_q;
   assign bus.busy   = busy_q;
   assign bus.switch = switch_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random traffic, each cycle
// compared against a holder/tenure model of the arbitration rules.
module tb_mux4_rr_arbiter;

   localparam int HOLD = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   mux4_rr_arbiter_if bus();

   mux4_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: holder index (-1 = idle), cycles held so far, rotation pointer.
   int m_holder, m_ten, m_ptr, m_s;
   bit m_sw;

   function automatic int first_from(input logic [3:0] r, input int from);
      for (int i = 0; i < 4; i++) begin
         if (r[(from + i) % 4]) return (from + i) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_holder = -1; m_ten = 0; m_ptr = 0; m_s = 0; m_sw = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] r);
      logic [3:0] oth;
      int w;
      m_sw = 1'b0;
      if (m_holder < 0) begin
         w = first_from(r, m_ptr);
         if (w >= 0) begin
            m_holder = w; m_ten = 1; m_ptr = (w + 1) % 4; m_s = w;
         end
      end else begin
         oth = r;
         oth[m_holder] = 1'b0;
         if (r[m_holder] && m_ten < HOLD) begin
            m_ten++;
         end else if (oth != 4'b0000) begin
            w = first_from(oth, (m_holder + 1) % 4);
            m_holder = w; m_ten = 1; m_ptr = (w + 1) % 4; m_s = w; m_sw = 1'b1;
         end else if (r[m_holder]) begin
            m_ten = 1;
         end else begin
            m_holder = -1; m_ten = 0;
         end
      end
   endtask

   function automatic logic [7:0] model_vec();
      logic [3:0] g;
      g = (m_holder >= 0) ? (4'b0001 << m_holder) : 4'b0000;
      return {g, 2'(m_s), (m_holder >= 0), m_sw};
   endfunction

   function automatic logic [7:0] dut_vec();
      return {bus.gnt, bus.s, bus.busy, bus.switch};
   endfunction

   task automatic step(input logic [3:0] r);
      bus.req = r;
      @(posedge clk);
      model_step(r);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req = 4'b0000;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (dut_vec() !== 8'h00) begin
         errors++; $display("FAIL reset_values got %b want 00000000", dut_vec());
      end
      step(4'b0100);
      checks++;
      if (bus.gnt !== 4'b0100) begin
         errors++; $display("FAIL reset_pre_grant gnt got %b want 0100", bus.gnt);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({bus.gnt, bus.s, bus.busy} !== 7'b0) begin
         errors++; $display("FAIL reset_async gnt/s/busy got %b want 0000000", {bus.gnt, bus.s, bus.busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b1000);
      checks++;
      if (bus.gnt !== 4'b1000 || bus.s !== 2'b11 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL reset_first_grant got gnt=%b s=%b want gnt=1000 s=11", bus.gnt, bus.s);
      end
   endtask

   task automatic test_single();
      do_reset();
      step(4'b0100);
      checks++;
      if (dut_vec() !== 8'b0100_10_1_0) begin
         errors++; $display("FAIL single_grant got %b want 01001010", dut_vec());
      end
      step(4'b0100);
      step(4'b0100);
      step(4'b0000);
      checks++;
      if (dut_vec() !== 8'b0000_10_0_0) begin
         errors++; $display("FAIL single_release got %b want 00001000", dut_vec());
      end
   endtask

   task automatic test_round_robin();
      int h;
      do_reset();
      step(4'b1111);
      for (int k = 0; k < 4; k++) begin
         h = k % 4;
         checks++;
         if (bus.gnt !== (4'b0001 << h) || bus.busy !== 1'b1 || bus.switch !== (k > 0)) begin
            errors++; $display("FAIL rr_grant_%0d got gnt=%b busy=%b sw=%b want gnt=%b", k, bus.gnt, bus.busy, bus.switch, 4'b0001 << h);
         end
         step(4'b1111);
         checks++;
         if (bus.gnt !== (4'b0001 << h) || bus.switch !== 1'b0) begin
            errors++; $display("FAIL rr_hold_%0d got gnt=%b sw=%b want gnt=%b sw=0", k, bus.gnt, bus.switch, 4'b0001 << h);
         end
         step(4'b1111 & ~(4'b0001 << h));
      end
      checks++;
      if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1 || bus.switch !== 1'b1) begin
         errors++; $display("FAIL rr_wrap got gnt=%b busy=%b sw=%b want 0001 1 1", bus.gnt, bus.busy, bus.switch);
      end
   endtask

   task automatic test_timeout_contention();
      logic [3:0] want;
      int bad;
      bad = 0;
      do_reset();
      for (int c = 0; c < 5 * HOLD; c++) begin
         step(4'b0011);
         want = 4'b0001 << ((c / HOLD) % 2);
         if (bus.gnt !== want || bus.switch !== (c > 0 && c % HOLD == 0) || bus.busy !== 1'b1) begin
            bad++;
            if (bad < 4) $display("FAIL timeout_cont cycle %0d got gnt=%b sw=%b want gnt=%b", c, bus.gnt, bus.switch, want);
         end
         if (dut_vec() !== model_vec()) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL timeout_cont_total got %0d bad cycles want 0", bad);
      end
   endtask

   task automatic test_timeout_no_contention();
      int bad;
      bad = 0;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         step(4'b0001);
         if (bus.gnt !== 4'b0001 || bus.switch !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL timeout_solo got %0d bad cycles want 0", bad);
      end
      // 20 held cycles leave the holder 4 cycles into its third window.
      for (int c = 0; c < HOLD - 4; c++) step(4'b0011);
      checks++;
      if (bus.gnt !== 4'b0001) begin
         errors++; $display("FAIL timeout_wrap_hold got gnt=%b want 0001", bus.gnt);
      end
      step(4'b0011);
      checks++;
      if (bus.gnt !== 4'b0010 || bus.switch !== 1'b1) begin
         errors++; $display("FAIL timeout_wrap_switch got gnt=%b sw=%b want 0010 1", bus.gnt, bus.switch);
      end
   endtask

   task automatic test_handover_wrap();
      do_reset();
      step(4'b1000);
      step(4'b1010);
      checks++;
      if (bus.gnt !== 4'b1000 || bus.s !== 2'b11) begin
         errors++; $display("FAIL wrap_holder got gnt=%b s=%b want 1000 11", bus.gnt, bus.s);
      end
      step(4'b0010);
      checks++;
      if (dut_vec() !== 8'b0010_01_1_1) begin
         errors++; $display("FAIL wrap_handover got %b want 00100111", dut_vec());
      end
      step(4'b0101);
      checks++;
      if (bus.gnt !== 4'b0100 || bus.s !== 2'b10) begin
         errors++; $display("FAIL wrap_next_search got gnt=%b s=%b want 0100 10", bus.gnt, bus.s);
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      int bad;
      bad = 0;
      r = 4'b0000;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         step(r);
         if (dut_vec() !== model_vec()) begin
            bad++;
            if (bad < 5) $display("FAIL random cycle %0d req=%b got %b want %b", c, r, dut_vec(), model_vec());
         end
         if (!$onehot0(bus.gnt) || bus.busy !== (|bus.gnt)) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL random_total got %0d bad cycles want 0", bad);
      end
   endtask

   initial begin
      bus.req = 4'b0000;
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_timeout_contention();
      test_timeout_no_contention();
      test_handover_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
